divu_hilo_ctl: RTL and testbench



---
 rtl/divu_hilo_ctl_if.sv | 31 +++
 rtl/divu_hilo_ctl.sv | 96 +++++++++
 tb/tb_divu_hilo_ctl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/divu_hilo_ctl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : divu_hilo_ctl_if
// Purpose  : EX-stage request/result bundle between the pipeline and the
//            unsigned-divide HI/LO sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface divu_hilo_ctl_if #(
   parameter int WIDTH = 32
);
   logic             div_start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             hilo_rd;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output div_start, dividend, divisor, hilo_rd,
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  div_start, dividend, divisor, hilo_rd,
      output busy, stall, done, hi, lo
   );
endinterface
`default_nettype wire

// File: rtl/divu_hilo_ctl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : divu_hilo_ctl
// Purpose  : Restoring shift-subtract DIVU sequencer, one quotient bit per
//            cycle, writing LO=quotient / HI=remainder and raising the stall.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module divu_hilo_ctl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  wire               clk,
   input  wire               rst_n,
   divu_hilo_ctl_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_dreg;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [WIDTH:0]   w_trial;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quot_next;
   logic             w_busy;

   // A restored remainder is always below the divisor, so WIDTH bits hold it;
   // only the trial value needs the extra shifted-in bit.
   always_comb begin
      w_trial     = {r_rem, r_quot[WIDTH-1]};
      w_ge        = (w_trial >= {1'b0, r_dreg});
      w_diff      = w_trial[WIDTH-1:0] - r_dreg;
      w_rem_next  = w_ge ? w_diff : w_trial[WIDTH-1:0];
      w_quot_next = {r_quot[WIDTH-2:0], w_ge};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_dreg  <= '0;
         r_quot  <= '0;
         r_rem   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               // DONE accepts a waiting DIVU directly, giving back-to-back divides.
               if (bus.div_start) begin
                  r_dreg  <= bus.divisor;
                  r_quot  <= bus.dividend;
                  r_rem   <= '0;
                  r_count <= '0;
                  r_state <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_quot  <= w_quot_next;
               r_rem   <= w_rem_next;
               r_count <= r_count + CNT_W'(1);
               if (r_count == c_last_iter) begin
                  r_lo    <= w_quot_next;
                  r_hi    <= w_rem_next;
                  r_state <= S_DONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_busy    = (r_state == S_RUN);
   assign bus.busy  = w_busy;
   assign bus.done  = (r_state == S_DONE);
   assign bus.stall = w_busy & (bus.hilo_rd | bus.div_start);
   assign bus.hi    = r_hi;
   assign bus.lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_divu_hilo_ctl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_divu_hilo_ctl
// Purpose  : Self-checking bench for divu_hilo_ctl with a result scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_divu_hilo_ctl;

   localparam int c_width   = 32;
   localparam int c_latency = 33;

   typedef struct {
      logic [31:0] dvd;
      logic [31:0] dvs;
      logic [31:0] exp_lo;
      logic [31:0] exp_hi;
   } vec_t;

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb[$];
   vec_t vecs[6];

   divu_hilo_ctl_if #(.WIDTH(c_width)) bus();

   divu_hilo_ctl #(.WIDTH(c_width), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: every done pulse must match the oldest outstanding divide.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
            check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
            check("latency_cycle", 64'(cyc), 64'(e.cyc));
            check("busy_in_done", {63'd0, bus.busy}, 64'd0);
         end
      end
   end

   task automatic push_exp(input logic [31:0] lo, input logic [31:0] hi, input int at_cyc);
      exp_t e;
      e.lo  = lo;
      e.hi  = hi;
      e.cyc = at_cyc;
      sb.push_back(e);
   endtask

   task automatic run_one(input logic [31:0] dvd, input logic [31:0] dvs,
                          input logic [31:0] elo, input logic [31:0] ehi);
      int busy_cnt;
      bit stall_seen;
      bit done_seen;
      busy_cnt   = 0;
      stall_seen = 0;
      done_seen  = 0;
      @(posedge clk); #1;
      bus.div_start = 1'b1;
      bus.dividend  = dvd;
      bus.divisor   = dvs;
      push_exp(elo, ehi, cyc + c_latency);
      @(posedge clk); #1;
      bus.div_start = 1'b0;
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         @(negedge clk);
         if (bus.busy)  busy_cnt++;
         if (bus.stall) stall_seen = 1;
         if (bus.done)  done_seen = 1;
      end
      check("done_seen", {63'd0, done_seen}, 64'd1);
      check("busy_cycles", 64'(busy_cnt), 64'd32);
      check("stall_idle_requesters", {63'd0, stall_seen}, 64'd0);
   endtask

   initial begin
      int  busy_seen;
      bit  stall_bad;
      bit  done_seen;

      vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1] = '{32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234};
      vecs[2] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
      vecs[3] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
      vecs[4] = '{32'd12345678,   32'd1000,       32'd12345,      32'd678};
      vecs[5] = '{32'd5,          32'd9,          32'd0,          32'd5};

      bus.div_start = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      bus.hilo_rd   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy",  {63'd0, bus.busy},  64'd0);
      check("rst_done",  {63'd0, bus.done},  64'd0);
      check("rst_stall", {63'd0, bus.stall}, 64'd0);
      check("rst_hi",    {32'd0, bus.hi},    64'd0);
      check("rst_lo",    {32'd0, bus.lo},    64'd0);
      rst_n = 1'b1;

      foreach (vecs[k]) run_one(vecs[k].dvd, vecs[k].dvs, vecs[k].exp_lo, vecs[k].exp_hi);

      // MFHI/MFLO arriving at cycle 5 of 1000/3 and held until DONE
      @(posedge clk); #1;
      bus.div_start = 1'b1;
      bus.dividend  = 32'd1000;
      bus.divisor   = 32'd3;
      push_exp(32'd333, 32'd1, cyc + c_latency);
      @(posedge clk); #1;
      bus.div_start = 1'b0;
      repeat (5) @(posedge clk);
      #1 bus.hilo_rd = 1'b1;
      stall_bad = 0;
      done_seen = 0;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         @(negedge clk);
         if (bus.busy && !bus.stall) stall_bad = 1;
         if (bus.done) begin
            done_seen = 1;
            check("hilo_stall_in_done", {63'd0, bus.stall}, 64'd0);
            check("hilo_lo_in_done", {32'd0, bus.lo}, 64'd333);
            check("hilo_hi_in_done", {32'd0, bus.hi}, 64'd1);
         end
      end
      check("hilo_done_seen", {63'd0, done_seen}, 64'd1);
      check("hilo_stall_while_busy", {63'd0, stall_bad}, 64'd0);
      @(posedge clk); #1;
      bus.hilo_rd = 1'b0;

      // div_start held through a divide: 50/5 then 9/4 back-to-back
      @(posedge clk); #1;
      bus.div_start = 1'b1;
      bus.dividend  = 32'd50;
      bus.divisor   = 32'd5;
      push_exp(32'd10, 32'd0, cyc + c_latency);
      push_exp(32'd2,  32'd1, cyc + 2 * c_latency);
      @(posedge clk); #1;
      bus.dividend = 32'd9;
      bus.divisor  = 32'd4;
      stall_bad = 0;
      done_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         @(negedge clk);
         if (bus.busy) busy_seen++;
         if (bus.busy && !bus.stall) stall_bad = 1;
         if (bus.done) done_seen = 1;
      end
      check("b2b_first_done", {63'd0, done_seen}, 64'd1);
      check("b2b_stall_while_busy", {63'd0, stall_bad}, 64'd0);
      check("b2b_busy_cycles", 64'(busy_seen), 64'd32);
      @(posedge clk); #1;
      bus.div_start = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         @(negedge clk);
         if (bus.done) done_seen = 1;
      end
      check("b2b_second_done", {63'd0, done_seen}, 64'd1);

      // Asynchronous reset at cycle 10 of 77/6
      @(posedge clk); #1;
      bus.div_start = 1'b1;
      bus.dividend  = 32'd77;
      bus.divisor   = 32'd6;
      @(posedge clk); #1;
      bus.div_start = 1'b0;
      bus.hilo_rd   = 1'b1;
      repeat (9) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_busy",  {63'd0, bus.busy},  64'd0);
      check("arst_stall", {63'd0, bus.stall}, 64'd0);
      check("arst_done",  {63'd0, bus.done},  64'd0);
      check("arst_hi",    {32'd0, bus.hi},    64'd0);
      check("arst_lo",    {32'd0, bus.lo},    64'd0);
      bus.hilo_rd = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) done_seen = 1;
      end
      check("arst_no_activity", {63'd0, done_seen}, 64'd0);
      run_one(32'd77, 32'd6, 32'd12, 32'd5);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #60000;
      $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
